// File: rtl/instmem_loader.sv
// Streams header + payload configuration words into instmem_pe write strobes.
// Optional payload parity checking is enabled by defining INSTLOADER_PARITY_EN.
module instmem_loader #(
  parameter int WRITE_AWIDTH   = 6,
  parameter int WRITE_DWIDTH   = 64,
  parameter int DEPTH          = 64,
  parameter int SLOTS_PER_WORD = 3
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    exec_en,
  input  logic                    cfg_valid,
  input  logic [WRITE_DWIDTH-1:0] cfg_data,
  output logic                    cfg_ready,
  output logic                    Write_En,
  output logic [WRITE_AWIDTH-1:0] Write_Addr,
  output logic [WRITE_DWIDTH-1:0] In_Inst,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_err
);

  localparam int BW = WRITE_AWIDTH + 3;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                  state;
  logic [WRITE_AWIDTH-1:0] next_addr;
  logic [6:0]              cnt;
  logic [6:0]              idx;

  logic [7:0]              hdr_magic;
  logic [WRITE_AWIDTH-1:0] hdr_base;
  logic [6:0]              hdr_count;
  logic [BW-1:0]           end_slot;
  logic                    hdr_fits;
  logic                    par_ok;
  logic                    last_word;

  assign hdr_magic = cfg_data[WRITE_DWIDTH-1 -: 8];
  assign hdr_base  = cfg_data[8 +: WRITE_AWIDTH];
  assign hdr_count = cfg_data[6:0];

  // Bound check is done wide enough that base + 3*count can never wrap.
  assign end_slot  = BW'(hdr_base) + BW'(hdr_count) * BW'(SLOTS_PER_WORD);
  assign hdr_fits  = (end_slot <= BW'(DEPTH));
  assign last_word = (idx == cnt - 7'd1);

`ifdef INSTLOADER_PARITY_EN
  assign par_ok = ~^cfg_data;
`else
  assign par_ok = 1'b1;
`endif

  assign cfg_ready = Reset && !exec_en && (state != DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      next_addr  <= '0;
      cnt        <= '0;
      idx        <= '0;
      Write_En   <= 1'b0;
      Write_Addr <= '0;
      In_Inst    <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      Write_En  <= 1'b0;
      load_done <= 1'b0;
      if (!exec_en) begin
        case (state)
          IDLE: begin
            if (cfg_valid) begin
              if (hdr_magic != 8'hA5) begin
                load_err <= 1'b1;
              end else if (hdr_count == 7'd0) begin
                load_err <= 1'b0;
                state    <= DONE;
              end else if (hdr_fits) begin
                load_err  <= 1'b0;
                next_addr <= hdr_base;
                cnt       <= hdr_count;
                idx       <= '0;
                state     <= LOAD;
              end else begin
                load_err <= 1'b1;
                cnt      <= hdr_count;
                idx      <= '0;
                state    <= DRAIN;
              end
            end
          end
          LOAD: begin
            if (cfg_valid) begin
              // A parity-failed word still consumes its address slot.
              if (par_ok) begin
                Write_En   <= 1'b1;
                Write_Addr <= next_addr;
                In_Inst    <= cfg_data;
              end else begin
                load_err <= 1'b1;
              end
              next_addr <= next_addr + WRITE_AWIDTH'(SLOTS_PER_WORD);
              idx       <= idx + 7'd1;
              if (last_word) state <= DONE;
            end
          end
          DRAIN: begin
            if (cfg_valid) begin
              idx <= idx + 7'd1;
              if (last_word) state <= DONE;
            end
          end
          DONE: begin
            // Registered pulse lands one cycle after the final write.
            load_done <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instmem_loader.sv
// Directed bench for instmem_loader with a transaction-level scoreboard model.
module tb_instmem_loader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        exec_en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [63:0] cfg_data = '0;
  logic        cfg_ready;
  logic        Write_En;
  logic [5:0]  Write_Addr;
  logic [63:0] In_Inst;
  logic        busy;
  logic        load_done;
  logic        load_err;

  instmem_loader dut (
    .Clk(Clk), .Reset(Reset), .exec_en(exec_en), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .Write_En(Write_En),
    .Write_Addr(Write_Addr), .In_Inst(In_Inst), .busy(busy),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 Clk = ~Clk;

  localparam int NEVER = 32'h7fff_ffff;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_on = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [63:0] data;
    int          at;
  } wr_t;

  wr_t         exp_wr[$];
  int          last_addr;
  logic [63:0] last_data;
  logic        exp_err, err_next;
  int          err_at, busy_from, busy_to, done_at;
  bit          in_load, writing;
  int          ld_base, ld_count, ld_k;

  int          obs_addr[$];
  logic [63:0] obs_data[$];
  int          obs_wr_cyc[$];
  int          obs_done[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] mkp(input logic [63:0] x);
    logic [63:0] y;
    y = x;
    y[0] = ^x[63:1];
    return y;
  endfunction

  function automatic bit par_ok(input logic [63:0] w);
`ifdef INSTLOADER_PARITY_EN
    return w[0] == ^w[63:1];
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    exp_wr.delete();
    last_addr = 0;
    last_data = '0;
    exp_err   = 1'b0;
    err_next  = 1'b0;
    err_at    = NEVER;
    busy_from = NEVER;
    busy_to   = NEVER;
    done_at   = -1;
    in_load   = 0;
    writing   = 0;
  endtask

  // Word w was transferred on the edge ending cycle c.
  task automatic model_accept(input logic [63:0] w, input int c);
    if (!in_load) begin
      if (w[63:56] != 8'hA5) begin
        err_next = 1'b1;
        err_at   = c + 1;
      end else begin
        int base;
        int cnt;
        base      = int'(w[13:8]);
        cnt       = int'(w[6:0]);
        err_next  = (base + 3 * cnt > 64);
        err_at    = c + 1;
        busy_from = c + 1;
        if (cnt == 0) begin
          busy_to = c + 2;
          done_at = c + 2;
        end else begin
          busy_to  = NEVER;
          in_load  = 1;
          writing  = !err_next;
          ld_base  = base;
          ld_count = cnt;
          ld_k     = 0;
        end
      end
    end else begin
      if (writing && par_ok(w)) begin
        exp_wr.push_back('{ld_base + 3 * ld_k, w, c + 1});
      end else if (writing) begin
        err_next = 1'b1;
        err_at   = c + 1;
      end
      ld_k++;
      if (ld_k == ld_count) begin
        in_load = 0;
        busy_to = c + 2;
        done_at = c + 2;
      end
    end
  endtask

  always @(negedge Clk) begin
    if (mon_on) begin
      if (cyc >= err_at) exp_err = err_next;
      if (Write_En) begin
        obs_addr.push_back(int'(Write_Addr));
        obs_data.push_back(In_Inst);
        obs_wr_cyc.push_back(cyc);
        if (exp_wr.size() == 0 || exp_wr[0].at != cyc) begin
          chk("write_unexpected", Write_En, 0);
        end else begin
          chk("write_addr", Write_Addr, exp_wr[0].addr);
          chk("write_data", In_Inst, exp_wr[0].data);
          last_addr = exp_wr[0].addr;
          last_data = exp_wr[0].data;
          void'(exp_wr.pop_front());
        end
      end else if (exp_wr.size() > 0 && exp_wr[0].at == cyc) begin
        chk("write_missing", Write_En, 1);
        void'(exp_wr.pop_front());
      end else begin
        chk("hold_addr", Write_Addr, last_addr);
        chk("hold_data", In_Inst, last_data);
      end
      if (load_done) obs_done.push_back(cyc);
      chk("load_done", load_done, cyc == done_at);
      chk("load_err", load_err, exp_err);
      chk("busy", busy, (cyc >= busy_from) && (cyc < busy_to));
      chk("cfg_ready", cfg_ready, Reset && !exec_en && (cyc != done_at - 1));
    end
  end

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    obs_wr_cyc.delete();
    obs_done.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [63:0] w);
    bit r;
    bit ok;
    int c;
    ok = 0;
    cfg_valid = 1'b1;
    cfg_data  = w;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      r = cfg_ready;
      c = cyc;
      @(posedge Clk);
      if (r) begin
        model_accept(w, c);
        ok = 1;
        break;
      end
    end
    if (!ok) chk("handshake_timeout", cfg_ready, 1);
    #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p0, p1, p2, pa, pb, pc;
    p0 = mkp(64'h0123_4567_89AB_CDEE);
    p1 = mkp(64'hFEDC_BA98_7654_3210);
    p2 = mkp(64'h5555_AAAA_0F0F_F0F0);
    pa = mkp(64'h1111_2222_3333_4444);
    pb = mkp(64'h9999_8888_7777_6666) ^ 64'h1;
    pc = mkp(64'hDEAD_BEEF_CAFE_F00D);

    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_write_en", Write_En, 0);
    chk("rst_write_addr", Write_Addr, 0);
    chk("rst_in_inst", In_Inst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    Reset  = 1'b1;
    mon_on = 1;
    idle(1);

    // Basic two-word load at base 3.
    clear_obs();
    send(64'hA500_0000_0000_0302);
    send(p0);
    send(p1);
    idle(3);
    chk("t1_nwrites", obs_addr.size(), 2);
    chk("t1_addr0", obs_addr[0], 3);
    chk("t1_addr1", obs_addr[1], 6);
    chk("t1_data0", obs_data[0], p0);
    chk("t1_data1", obs_data[1], p1);
    chk("t1_back_to_back", obs_wr_cyc[1] - obs_wr_cyc[0], 1);
    chk("t1_ndone", obs_done.size(), 1);
    chk("t1_done_after_write", obs_done[0] - obs_wr_cyc[1], 1);
    chk("t1_err", load_err, 0);

    // Out-of-bounds header drains its payload.
    clear_obs();
    send(64'hA500_0000_0000_3C02);
    send(p0);
    send(p1);
    idle(3);
    chk("t2_nwrites", obs_addr.size(), 0);
    chk("t2_ndone", obs_done.size(), 1);
    chk("t2_err", load_err, 1);
    send(64'hA500_0000_0000_0000);
    idle(3);
    chk("t2_err_cleared", load_err, 0);
    chk("t2_ndone_after_empty", obs_done.size(), 2);

    // Bad magic while idle.
    clear_obs();
    send(64'h1234_5678_9ABC_DEF0);
    idle(2);
    chk("t3_err", load_err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_ndone", obs_done.size(), 0);

    // exec_en stall between payload 0 and 1.
    clear_obs();
    send(64'hA500_0000_0000_0A03);
    send(p0);
    exec_en = 1'b1;
    fork
      send(p1);
      begin
        repeat (5) @(posedge Clk);
        #1;
        exec_en = 1'b0;
      end
    join
    send(p2);
    idle(3);
    chk("t4_nwrites", obs_addr.size(), 3);
    chk("t4_addr0", obs_addr[0], 10);
    chk("t4_addr1", obs_addr[1], 13);
    chk("t4_addr2", obs_addr[2], 16);
    chk("t4_data2", obs_data[2], p2);
    chk("t4_stall_gap", obs_wr_cyc[1] - obs_wr_cyc[0], 6);
    chk("t4_err", load_err, 0);

    // Reset in the middle of a 4-word load.
    clear_obs();
    send(64'hA500_0000_0000_0004);
    send(p0);
    Reset = 1'b0;
    model_reset();
    #1;
    chk("t5_write_en", Write_En, 0);
    chk("t5_write_addr", Write_Addr, 0);
    chk("t5_in_inst", In_Inst, 0);
    chk("t5_busy", busy, 0);
    chk("t5_load_done", load_done, 0);
    chk("t5_load_err", load_err, 0);
    chk("t5_cfg_ready", cfg_ready, 0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
    idle(1);
    send(64'hA500_0000_0000_1401);
    send(p2);
    idle(3);
    chk("t5_nwrites", obs_addr.size(), 1);
    chk("t5_addr", obs_addr[0], 20);
    chk("t5_data", obs_data[0], p2);
    chk("t5_ndone", obs_done.size(), 1);

`ifdef INSTLOADER_PARITY_EN
    // Parity error on the middle word skips its slot.
    clear_obs();
    send(64'hA500_0000_0000_1E03);
    send(pa);
    send(pb);
    send(pc);
    idle(3);
    chk("t6_nwrites", obs_addr.size(), 2);
    chk("t6_addr0", obs_addr[0], 30);
    chk("t6_addr1", obs_addr[1], 36);
    chk("t6_data1", obs_data[1], pc);
    chk("t6_err", load_err, 1);
    chk("t6_ndone", obs_done.size(), 1);
`else
    // Without parity checking, bit 0 passes straight through.
    clear_obs();
    send(64'hA500_0000_0000_1E03);
    send(pa);
    send(pb);
    send(pc);
    idle(3);
    chk("t6_nwrites", obs_addr.size(), 3);
    chk("t6_addr1", obs_addr[1], 33);
    chk("t6_data1", obs_data[1], pb);
    chk("t6_err", load_err, 0);
`endif

    mon_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instmem_loader.md
Name: instmem_loader

Overview:
- Upstream feeder for instmem_pe: drives its Write_En / Write_Addr / In_Inst ports.
- Accepts a valid/ready stream of 64-bit configuration words from the CGRA configuration bus.
- Each stream starts with one header word (base address, payload count), followed by payload words of 3 packed 21-bit instructions each.
- Bounds-checks the load against memory depth and blocks all writes while the PE is executing.

Parameters:
- WRITE_AWIDTH, 6, instruction-memory write address width
- WRITE_DWIDTH, 64, configuration word width
- DEPTH, 64, instruction-memory entries (21-bit slots)
- SLOTS_PER_WORD, 3, instructions per payload word; address stride per write

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous active-low reset
- exec_en  in  1  PE executing; loader stalls while high
- cfg_valid  in  1  config word valid
- cfg_data  in  64  config word (header or payload)
- cfg_ready  out  1  loader accepts cfg_data this cycle
- Write_En  out  1  write strobe to instmem_pe
- Write_Addr  out  WRITE_AWIDTH  first slot of the 3-slot write
- In_Inst  out  WRITE_DWIDTH  payload word, passed unmodified
- busy  out  1  loader is not IDLE
- load_done  out  1  one-cycle pulse at end of a load
- load_err  out  1  sticky error; cleared by the next accepted valid header

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0, including load_err; all counters 0.
- Handshake: a word transfers when cfg_valid && cfg_ready.
  - cfg_ready = !exec_en && state in {IDLE, LOAD, DRAIN}.
  - cfg_ready is 0 in DONE.
  - exec_en high freezes the state and counters and forces Write_En = 0.
- Header fields:
  - cfg_data[63:56] = 8'hA5 (magic)
  - cfg_data[13:8] = base
  - cfg_data[6:0] = count, number of payload words (0..127)
  - Other bits are ignored.
- IDLE:
  - Accepted word with bad magic: dropped, load_err <= 1, stay IDLE.
  - Valid header, count == 0: go to DONE, load_err <= 0.
  - Valid header, base + 3*count <= DEPTH (compute with WRITE_AWIDTH+3 bits, no wrap): latch base and count; go to LOAD; load_err <= 0.
  - Valid header failing the bound check: load_err <= 1; go to DRAIN with count latched.
- LOAD:
  - Each accepted payload word k (0-based) produces, on the next cycle, Write_En = 1, Write_Addr = base + 3k, In_Inst = cfg_data. Latency is exactly 1 cycle; outputs are registered.
  - Write_En is 0 in any cycle with no acceptance on the previous edge.
  - After word count-1 is accepted, go to DONE.
- DRAIN: accept and discard count words with no Write_En, then go to DONE.
- DONE: load_done = 1 for exactly one cycle, then IDLE.
  - The final Write_En and load_done are on consecutive cycles: write first, then done.
- busy = (state != IDLE).
- Write_Addr and In_Inst hold their last values when Write_En = 0.
- Back-to-back payload with cfg_valid held high gives one write per cycle (full throughput).
- exec_en rising mid-load: a write already registered from the previous edge still issues; nothing further until exec_en falls, then the load resumes at the next k.
- Reset mid-load: abort immediately; the partial program stays in instmem_pe (its own reset clears entries).

Optional Feature:
- Macro: INSTLOADER_PARITY_EN.
- Defined:
  - Payload bit 0, which instmem_pe does not store, carries even parity over cfg_data[63:1].
  - A mismatching payload word in LOAD is not written (no Write_En for that k; its address slot is skipped) and load_err <= 1.
  - The load continues to DONE.
  - Headers are not parity-checked.
- Undefined: bit 0 is ignored and passed through in In_Inst.

Test Plan:
- Header 64'hA500_0000_0000_0302 (base 3, count 2), then payloads P0, P1 back-to-back -> Write_En on 2 consecutive cycles, Write_Addr 3 then 6, In_Inst P0 then P1; load_done on the next cycle; load_err 0.
- Header base 60, count 2 (60+6 > 64) plus 2 payloads -> both payloads accepted, zero Write_En, load_err = 1, load_done pulses; a following valid header clears load_err.
- Word 64'h1234_... while IDLE -> dropped, load_err = 1, busy stays 0.
- exec_en = 1 for 5 cycles between payload 0 and payload 1 of a count-3 load -> cfg_ready = 0 and no Write_En during the stall; addresses base, base+3, base+6 preserved.
- Reset asserted after 1 of 4 payloads -> all outputs 0 immediately; next header starts a fresh load.
- With INSTLOADER_PARITY_EN: payload with bad bit 0 at k = 1 of 3 -> writes at base and base+6 only; load_err = 1.
